// File: rtl/rgb_stream_packer_if.sv
// Pixel input and packed AXI4-Stream output bundles
// for the RGB stream packer.
interface rgb_pix_if;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       valid;
  logic       sof;
  logic       eol;
  logic       in_stream_ready;

  modport master (
    output r, g, b, valid, sof, eol,
    input  in_stream_ready
  );
  modport slave (
    input  r, g, b, valid, sof, eol,
    output in_stream_ready
  );
endinterface

interface rgb_axis_if;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;

  modport master (
    output out_stream_tdata, out_stream_tkeep,
    output out_stream_tlast, out_stream_tuser,
    output out_stream_tvalid,
    input  out_stream_tready
  );
  modport slave (
    input  out_stream_tdata, out_stream_tkeep,
    input  out_stream_tlast, out_stream_tuser,
    input  out_stream_tvalid,
    output out_stream_tready
  );
endinterface

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels densely into 32-bit AXI4-Stream
// words (4 pixels -> 3 words), with line-end flush and 2-deep output buffer.
module rgb_stream_packer (
  input  logic       aclk,
  input  logic       aresetn,
  rgb_pix_if.slave   pix,
  rgb_axis_if.master axo
);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  logic [1:0]  r_phase;
  logic [23:0] r_hold;
  logic        r_flush_pending;
  logic [15:0] r_flush_data;
  logic [3:0]  r_flush_keep;
  logic        r_tuser_pending;
  word_t       r_mem [2];
  logic        r_rd_ptr;
  logic [1:0]  r_cnt;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_pop;
  logic        w_push;
  logic        w_flush_go;
  logic        w_tvalid;
  logic [23:0] w_pix;
  logic [1:0]  w_ph;
  word_t       w_word;
  word_t       w_head;
  logic [1:0]  w_phase_nxt;
  logic [23:0] w_hold_nxt;
  logic        w_fp_nxt;
  logic [15:0] w_fd_nxt;
  logic [3:0]  w_fk_nxt;
  logic        w_tu_nxt;

  assign w_in_ready = aresetn && !r_flush_pending
                      && (r_cnt != 2'd2);
  assign w_accept   = pix.valid && w_in_ready;
  assign w_tvalid   = (r_cnt != 2'd0);
  assign w_pop      = w_tvalid && axo.out_stream_tready;
  assign w_flush_go = r_flush_pending
                      && ((r_cnt != 2'd2) || w_pop);
  assign w_pix      = {pix.r, pix.g, pix.b};
  // sof restarts packing: held bytes are dropped
  assign w_ph       = pix.sof ? 2'd0 : r_phase;

  always_comb begin
    w_push      = 1'b0;
    w_word      = '0;
    w_phase_nxt = r_phase;
    w_hold_nxt  = r_hold;
    w_fp_nxt    = r_flush_pending;
    w_fd_nxt    = r_flush_data;
    w_fk_nxt    = r_flush_keep;
    w_tu_nxt    = r_tuser_pending;
    if (w_flush_go) begin
      w_push      = 1'b1;
      w_word.data = {16'h0, r_flush_data};
      w_word.keep = r_flush_keep;
      w_word.last = 1'b1;
      w_word.user = r_tuser_pending;
      w_fp_nxt    = 1'b0;
      w_tu_nxt    = 1'b0;
    end else if (w_accept) begin
      w_word.keep = 4'hF;
      w_word.user = r_tuser_pending | pix.sof;
      unique case (w_ph)
        2'd0: begin
          if (pix.eol) begin
            w_push      = 1'b1;
            w_word.data = {8'h0, w_pix};
            w_word.keep = 4'h7;
            w_word.last = 1'b1;
            w_phase_nxt = 2'd0;
          end else begin
            w_hold_nxt  = w_pix;
            w_phase_nxt = 2'd1;
          end
        end
        2'd1: begin
          w_push      = 1'b1;
          w_word.data = {w_pix[7:0], r_hold};
          if (pix.eol) begin
            w_fp_nxt    = 1'b1;
            w_fd_nxt    = w_pix[23:8];
            w_fk_nxt    = 4'h3;
            w_phase_nxt = 2'd0;
          end else begin
            w_hold_nxt  = {8'h0, w_pix[23:8]};
            w_phase_nxt = 2'd2;
          end
        end
        2'd2: begin
          w_push      = 1'b1;
          w_word.data = {w_pix[15:0], r_hold[15:0]};
          if (pix.eol) begin
            w_fp_nxt    = 1'b1;
            w_fd_nxt    = {8'h0, w_pix[23:16]};
            w_fk_nxt    = 4'h1;
            w_phase_nxt = 2'd0;
          end else begin
            w_hold_nxt  = {16'h0, w_pix[23:16]};
            w_phase_nxt = 2'd3;
          end
        end
        2'd3: begin
          w_push      = 1'b1;
          w_word.data = {w_pix, r_hold[7:0]};
          w_word.last = pix.eol;
          w_phase_nxt = 2'd0;
        end
      endcase
      w_tu_nxt = w_push ? 1'b0
                        : (r_tuser_pending | pix.sof);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_phase         <= 2'd0;
      r_hold          <= '0;
      r_flush_pending <= 1'b0;
      r_flush_data    <= '0;
      r_flush_keep    <= '0;
      r_tuser_pending <= 1'b0;
      r_mem[0]        <= '0;
      r_mem[1]        <= '0;
      r_rd_ptr        <= 1'b0;
      r_cnt           <= 2'd0;
    end else begin
      r_phase         <= w_phase_nxt;
      r_hold          <= w_hold_nxt;
      r_flush_pending <= w_fp_nxt;
      r_flush_data    <= w_fd_nxt;
      r_flush_keep    <= w_fk_nxt;
      r_tuser_pending <= w_tu_nxt;
      if (w_push)
        r_mem[r_rd_ptr ^ r_cnt[0]] <= w_word;
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, w_push}
                     - {1'b0, w_pop};
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign pix.in_stream_ready   = w_in_ready;
  assign axo.out_stream_tvalid = w_tvalid;
  assign axo.out_stream_tdata  = w_tvalid ? w_head.data : '0;
  assign axo.out_stream_tkeep  = w_tvalid ? w_head.keep : '0;
  assign axo.out_stream_tlast  = w_tvalid && w_head.last;
  assign axo.out_stream_tuser  = w_tvalid && w_head.user;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Randomized and directed bench for rgb_stream_packer,
// scored against a byte-queue reference model.
module tb_rgb_stream_packer;

  logic aclk;
  logic aresetn;

  rgb_pix_if  pix ();
  rgb_axis_if axo ();

  rgb_stream_packer dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .pix     (pix),
    .axo     (axo)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tot = 0;
  int n_bad = 0;

  logic [7:0]  bq [$];
  logic [37:0] eq [$];
  logic        tu = 1'b0;
  int          n_words = 0;
  int          n_user = 0;
  int          n_last = 0;
  int          ready_lows = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [37:0] prev_w = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] cur();
    return {axo.out_stream_tdata, axo.out_stream_tkeep,
            axo.out_stream_tlast, axo.out_stream_tuser};
  endfunction

  // Reference: pixels become a byte stream, cut into 4-byte words
  task automatic model_px(input logic [23:0] p,
                          input logic s, input logic e);
    logic [31:0] d;
    int n;
    if (s) begin
      bq.delete();
      tu = 1'b1;
    end
    bq.push_back(p[7:0]);
    bq.push_back(p[15:8]);
    bq.push_back(p[23:16]);
    while (bq.size() >= 4) begin
      d = '0;
      for (int i = 0; i < 4; i++) d[8*i +: 8] = bq.pop_front();
      eq.push_back({d, 4'hF, e && (bq.size() == 0), tu});
      tu = 1'b0;
    end
    if (e && bq.size() > 0) begin
      n = bq.size();
      d = '0;
      for (int i = 0; i < n; i++) d[8*i +: 8] = bq.pop_front();
      eq.push_back({d, 4'((1 << n) - 1), 1'b1, tu});
      tu = 1'b0;
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      bq.delete();
      eq.delete();
      tu = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (axo.out_stream_tvalid && axo.out_stream_tready) begin
        if (eq.size() == 0) chk("unexpected_word", 64'(cur()), 64'h0);
        else chk("word", 64'(cur()), 64'(eq.pop_front()));
        n_words++;
        if (axo.out_stream_tuser) n_user++;
        if (axo.out_stream_tlast) n_last++;
      end
      if (prev_v && !prev_r)
        chk("head_hold", {axo.out_stream_tvalid, cur()}, {1'b1, prev_w});
      prev_v = axo.out_stream_tvalid;
      prev_r = axo.out_stream_tready;
      prev_w = cur();
      if (pix.valid && pix.in_stream_ready)
        model_px({pix.r, pix.g, pix.b}, pix.sof, pix.eol);
      if (!pix.in_stream_ready) ready_lows++;
    end
  end

  task automatic send(input logic [23:0] p,
                      input logic s, input logic e);
    int n = 0;
    pix.r = p[23:16];
    pix.g = p[15:8];
    pix.b = p[7:0];
    pix.sof = s;
    pix.eol = e;
    pix.valid = 1'b1;
    @(negedge aclk);
    while (!pix.in_stream_ready && n < 200) begin
      n++;
      @(negedge aclk);
    end
    if (n >= 200) chk("send_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    pix.valid = 1'b0;
    pix.sof = 1'b0;
    pix.eol = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  int   base_w, base_u, base_l, base_r;
  logic rnd_on;

  initial begin
    aresetn = 1'b0;
    pix.r = '0; pix.g = '0; pix.b = '0;
    pix.valid = 1'b0; pix.sof = 1'b0; pix.eol = 1'b0;
    axo.out_stream_tready = 1'b1;
    rnd_on = 1'b0;
    #3;
    chk("rst_tvalid", 64'(axo.out_stream_tvalid), 64'd0);
    chk("rst_word", 64'(cur()), 64'd0);
    chk("rst_ready", 64'(pix.in_stream_ready), 64'd0);
    repeat (3) @(posedge aclk);
    #2 aresetn = 1'b1;
    #1 chk("rel_ready", 64'(pix.in_stream_ready), 64'd1);
    idle(1);

    // four pixels, one word per pixel after the first
    base_r = ready_lows;
    send(24'h030201, 1'b0, 1'b0);
    chk("t1_novalid", 64'(axo.out_stream_tvalid), 64'd0);
    send(24'h060504, 1'b0, 1'b0);
    chk("t1_w0", 64'(cur()), {26'h0, 32'h04030201, 4'hF, 2'b00});
    send(24'h090807, 1'b0, 1'b0);
    chk("t1_w1", 64'(cur()), {26'h0, 32'h08070605, 4'hF, 2'b00});
    send(24'h0C0B0A, 1'b0, 1'b0);
    chk("t1_w2", 64'(cur()), {26'h0, 32'h0C0B0A09, 4'hF, 2'b00});
    idle(3);
    chk("t1_ready_lows", 64'(ready_lows - base_r), 64'd0);

    // full 640-pixel line
    base_w = n_words; base_u = n_user; base_l = n_last;
    for (int i = 0; i < 640; i++)
      send(24'($urandom), i == 0, i == 639);
    idle(4);
    chk("t2_words", 64'(n_words - base_w), 64'd480);
    chk("t2_user", 64'(n_user - base_u), 64'd1);
    chk("t2_last", 64'(n_last - base_l), 64'd1);

    // two-pixel line: eol at phase 1 forces a flush word
    base_r = ready_lows;
    send(24'h030201, 1'b0, 1'b0);
    send(24'h060504, 1'b0, 1'b1);
    chk("t3_w0", 64'(cur()), {26'h0, 32'h04030201, 4'hF, 2'b00});
    idle(1);
    chk("t3_flush", 64'(cur()), {26'h0, 32'h00000605, 4'h3, 2'b10});
    idle(3);
    chk("t3_ready_lows", 64'(ready_lows - base_r), 64'd1);

    // sink stall while pixels keep arriving
    base_r = ready_lows;
    base_w = n_words;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(24'($urandom), 1'b0, i == 11);
      end
      begin
        axo.out_stream_tready = 1'b0;
        idle(6);
        chk("t4_ready_low", 64'(pix.in_stream_ready), 64'd0);
        chk("t4_tvalid", 64'(axo.out_stream_tvalid), 64'd1);
        idle(4);
        axo.out_stream_tready = 1'b1;
      end
    join
    idle(4);
    chk("t4_stalled", 64'(ready_lows - base_r > 0), 64'd1);
    chk("t4_words", 64'(n_words - base_w), 64'd9);

    // sof at phase 2 discards held bytes
    send(24'h111111, 1'b0, 1'b0);
    send(24'h222222, 1'b0, 1'b0);
    send(24'h0A0B0C, 1'b1, 1'b1);
    chk("t5_word", 64'(cur()), {26'h0, 32'h000A0B0C, 4'h7, 2'b11});
    idle(3);

    // asynchronous reset with two words buffered
    axo.out_stream_tready = 1'b0;
    send(24'h0F0E0D, 1'b0, 1'b0);
    send(24'h121110, 1'b0, 1'b0);
    send(24'h151413, 1'b0, 1'b0);
    chk("t6_full", 64'(pix.in_stream_ready), 64'd0);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_tvalid", 64'(axo.out_stream_tvalid), 64'd0);
    chk("t6_word", 64'(cur()), 64'd0);
    chk("t6_ready", 64'(pix.in_stream_ready), 64'd0);
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    #1 chk("t6_rel_ready", 64'(pix.in_stream_ready), 64'd1);
    axo.out_stream_tready = 1'b1;
    idle(1);
    send(24'h030201, 1'b0, 1'b0);
    send(24'h060504, 1'b0, 1'b0);
    chk("t6_w0", 64'(cur()), {26'h0, 32'h04030201, 4'hF, 2'b00});
    send(24'h090807, 1'b0, 1'b0);
    send(24'h0C0B0A, 1'b0, 1'b1);
    chk("t6_w2", 64'(cur()), {26'h0, 32'h0C0B0A09, 4'hF, 2'b10});
    idle(3);

    // random traffic against the model
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(24'($urandom), $urandom_range(0, 49) == 0,
               $urandom_range(0, 19) == 0);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge aclk);
          #1 axo.out_stream_tready = ($urandom_range(0, 3) != 0);
        end
        axo.out_stream_tready = 1'b1;
      end
    join
    idle(10);
    chk("drain_empty", 64'(eq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
